// File: rtl/car_sim_pkg.sv
// Shared definitions for the car simulator fabric: responder FSM encoding,
// ADC channel numbering and the 8-bit to 12-bit code expansion.
package car_sim_pkg;

    // Responder FSM encoding (kept as plain constants for legacy tooling)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_NULL = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_TAIL = 3'd4;

    // ODD bit of the command selects the channel
    localparam logic CH_ACCEL = 1'b0;
    localparam logic CH_CDS   = 1'b1;

    localparam int ADC_CMD_BITS = 4;
    localparam int ADC_CODE_W   = 12;

    // Stretch an 8-bit value to full 12-bit scale: 00->000, FF->FFF
    function automatic logic [ADC_CODE_W-1:0] expand_code(input logic [7:0] v);
        return {v, v[7:4]};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchronizer for one asynchronous SPI pin with rise/fall strobes.
// The strobes compare the last synchronizer stage against one extra
// registered copy, so they are one CLK wide and glitch free.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic global_safe_rst,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer and keep the previous settled level
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating a 2-channel 12-bit ADC with MCP3202-style framing.
// Channel codes come from fabric (8-bit) and are expanded to 12 bits.
// All SPI pins are oversampled by CLK; SCK is CPOL=0, MOSI captured on
// rising SCK, MISO launched on falling SCK.
module spi_adc_responder
    import car_sim_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CODE_W      = ADC_CODE_W,
    parameter int CMD_BITS    = ADC_CMD_BITS
) (
    input  logic       CLK,
    input  logic       global_safe_rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       miso_oe,
    input  logic [7:0] ch0_code,
    input  logic [7:0] ch1_code,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [3:0] CMD_LAST = 4'(CMD_BITS - 1);
    localparam logic [3:0] CODE_MSB = 4'(CODE_W - 1);
    localparam logic [3:0] CODE_END = 4'(CODE_W);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic [2:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d;
    logic [CODE_W-1:0]   result_q, result_d;
    logic                done_seen_q, done_seen_d;
    logic                miso_q, miso_d;
    logic                oe_q, oe_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Before the MSBF shift the register holds {.., START, SGL, ODD};
    // after it, {START, SGL, ODD, MSBF}.
    logic sgl_now, odd_now, start_bit, sgl_bit, msbf_bit;
    assign sgl_now   = cmd_q[1];
    assign odd_now   = cmd_q[0];
    assign start_bit = cmd_q[CMD_BITS-1];
    assign sgl_bit   = cmd_q[CMD_BITS-2];
    assign msbf_bit  = cmd_q[0];

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .CLK             (CLK),
        .global_safe_rst (global_safe_rst),
        .pin_i           (spi_sck),
        .rise_o          (sck_rise),
        .fall_o          (sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .CLK             (CLK),
        .global_safe_rst (global_safe_rst),
        .pin_i           (spi_cs_n),
        .rise_o          (cs_rise),
        .fall_o          (cs_fall)
    );

    // MOSI only needs level synchronisation; it is sampled on the SCK rise strobe
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Frame sequencing: command capture, null bit, MSB-first data, optional LSB-first tail
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        result_d    = result_q;
        done_seen_d = done_seen_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (state_q != ST_IDLE && cs_rise) begin
            // Deselect wins over any coincident SCK edge
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            err_d   = ~done_seen_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d     = ST_CMD;
                        oe_d        = 1'b1;
                        miso_d      = 1'b0;
                        cnt_d       = '0;
                        cmd_d       = '0;
                        result_d    = '0;
                        done_seen_d = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        if (cnt_q == '0) begin
                            // Leading zeros are ignored until START
                            if (mosi_s) begin
                                cmd_d = {{(CMD_BITS-1){1'b0}}, 1'b1};
                                cnt_d = 4'd1;
                            end
                        end else begin
                            cmd_d = {cmd_q[CMD_BITS-2:0], mosi_s};
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q == CMD_LAST) begin
                                // MSBF bit: freeze the selected code for the whole frame
                                state_d = ST_NULL;
                                cnt_d   = '0;
                                if (sgl_now) begin
                                    result_d = expand_code((odd_now == CH_CDS) ? ch1_code : ch0_code);
                                end else begin
                                    result_d = '0;
                                    err_d    = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_NULL: begin
                    if (sck_fall) begin
                        miso_d  = 1'b0;
                        state_d = ST_DATA;
                        cnt_d   = CODE_MSB;
                    end
                end
                ST_DATA: begin
                    if (sck_fall) begin
                        miso_d = result_q[cnt_q];
                        if (cnt_q == '0) begin
                            state_d = ST_TAIL;
                            cnt_d   = 4'd1;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    // First rise here is the one where the initiator reads B0
                    if (sck_rise && !done_seen_q && start_bit && sgl_bit) begin
                        done_d      = 1'b1;
                        done_seen_d = 1'b1;
                    end
                    if (sck_fall) begin
                        if (!msbf_bit && cnt_q < CODE_END) begin
                            miso_d = result_q[cnt_q];
                            cnt_d  = cnt_q + 4'd1;
                        end else begin
                            miso_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // Frame state and output registers
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            result_q    <= '0;
            done_seen_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            result_q    <= result_d;
            done_seen_q <= done_seen_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign spi_miso   = miso_q & oe_q;
    assign miso_oe    = oe_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
